// File: rtl/dma_sched_ctrl.sv
// Shares one DMA transfer engine among N_CHANNELS channels: strict priority, round-robin ties, beat quantum.
// Optional feature macro DMA_SCHED_AGING_EN promotes a channel after AGE_LIMIT lost arbitrations.
module dma_sched_ctrl #(
    parameter int  N_CHANNELS    = 4,
    parameter int  PRIO_W        = 2,
    parameter int  QUANTUM_BEATS = 16,
    parameter int  AGE_LIMIT     = 15,
    localparam int CW            = $clog2(N_CHANNELS)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_CHANNELS-1:0]        ch_en_i,
    input  logic [N_CHANNELS-1:0]        ch_pend_i,
    input  logic [N_CHANNELS*PRIO_W-1:0] ch_prio_i,
    input  logic [N_CHANNELS-1:0]        periph_mode_i,
    input  logic [N_CHANNELS-1:0]        periph_req_i,
    output logic [N_CHANNELS-1:0]        periph_ack_o,
    output logic                         start_o,
    output logic [CW-1:0]                start_ch_o,
    input  logic                         start_ready_i,
    input  logic                         beat_i,
    input  logic                         done_i,
    input  logic                         paused_i,
    output logic                         pause_o,
    output logic [N_CHANNELS-1:0]        grant_o,
    output logic                         busy_o
);
    localparam int            BW       = $clog2(QUANTUM_BEATS + 1);
    localparam logic [BW-1:0] BCNT_MAX = BW'(QUANTUM_BEATS);
    localparam logic [CW-1:0] LAST_CH  = CW'(N_CHANNELS - 1);

    if (N_CHANNELS < 2 || QUANTUM_BEATS < 1 || AGE_LIMIT < 1) begin : g_bad_params
        $error("dma_sched_ctrl: N_CHANNELS>=2, QUANTUM_BEATS>=1 and AGE_LIMIT>=1 are required");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DRAIN} state_t;

    state_t                state_q;
    logic [CW-1:0]         cur_q;
    logic [CW-1:0]         rr_ptr_q;
    logic [CW-1:0]         rr_next;
    logic [CW-1:0]         win_ch;
    logic [BW-1:0]         bcnt_q;
    logic [BW-1:0]         bcnt_d;
    logic [N_CHANNELS-1:0] preq_q;
    logic [N_CHANNELS-1:0] preq_d;
    logic [N_CHANNELS-1:0] elig;
    logic [N_CHANNELS-1:0] win_oh;
    logic [N_CHANNELS-1:0] cur_oh;
    logic [N_CHANNELS-1:0] ack_d;
    logic [N_CHANNELS-1:0] ack_q;
    logic [N_CHANNELS-1:0] grant_q;
    logic                  start_q;
    logic                  pause_q;
    logic                  busy_q;
    logic                  any_elig;
    logic                  quantum_hit;
    logic                  cur_en;
    logic                  cur_pmode;
    logic [PRIO_W:0]       eff_prio [N_CHANNELS];
    logic [PRIO_W:0]       best_prio;

    genvar gi;
    for (gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
        assign elig[gi]   = ch_en_i[gi] & ch_pend_i[gi] & (~periph_mode_i[gi] | preq_q[gi]);
        assign win_oh[gi] = (win_ch == CW'(gi));
        assign cur_oh[gi] = (cur_q == CW'(gi));
    end

`ifdef DMA_SCHED_AGING_EN
    localparam int            AW      = $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

    logic [AW-1:0] age_q [N_CHANNELS];
    logic          decide;

    assign decide = (state_q == S_IDLE) && any_elig;

    // Ages only advance on an arbitration the channel loses; dropping out of eligibility forgets them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CHANNELS; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (!elig[i] || (decide && win_oh[i])) begin
                    age_q[i] <= '0;
                end else if (decide && age_q[i] != AGE_MAX) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    // The extra MSB lifts every aged channel above all unaged ones; aged channels then tie among themselves.
    for (gi = 0; gi < N_CHANNELS; gi++) begin : g_eff_aged
        assign eff_prio[gi] = (age_q[gi] == AGE_MAX) ? {1'b1, {PRIO_W{1'b0}}}
                                                     : {1'b0, ch_prio_i[gi*PRIO_W +: PRIO_W]};
    end
`else
    for (gi = 0; gi < N_CHANNELS; gi++) begin : g_eff_plain
        assign eff_prio[gi] = {1'b0, ch_prio_i[gi*PRIO_W +: PRIO_W]};
    end
`endif

    // First pass finds the top priority, second pass takes the first match scanning from rr_ptr.
    always_comb begin
        int            idx;
        logic          found;
        logic [CW-1:0] sel;
        idx       = 0;
        found     = 1'b0;
        sel       = '0;
        best_prio = '0;
        any_elig  = 1'b0;
        win_ch    = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (elig[i]) begin
                any_elig = 1'b1;
                if (eff_prio[i] > best_prio) best_prio = eff_prio[i];
            end
        end
        for (int i = 0; i < N_CHANNELS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
            sel = idx[CW-1:0];
            if (!found && elig[sel] && eff_prio[sel] == best_prio) begin
                win_ch = sel;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        bcnt_d = bcnt_q;
        if (beat_i && bcnt_q != BCNT_MAX) bcnt_d = bcnt_q + 1'b1;
    end

    assign quantum_hit = (bcnt_d == BCNT_MAX);
    assign rr_next     = (cur_q == LAST_CH) ? '0 : cur_q + 1'b1;
    assign cur_en      = ch_en_i[cur_q];
    assign cur_pmode   = periph_mode_i[cur_q];
    assign ack_d       = ((state_q == S_RUN || state_q == S_DRAIN) && done_i && cur_pmode) ? cur_oh : '0;
    // The request is dropped together with issuing the ack so the channel cannot win the following idle cycle.
    assign preq_d      = (preq_q & ~ack_d) | periph_req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            preq_q <= '0;
        end else begin
            preq_q <= preq_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            rr_ptr_q <= '0;
            bcnt_q   <= '0;
            start_q  <= 1'b0;
            pause_q  <= 1'b0;
            busy_q   <= 1'b0;
            grant_q  <= '0;
            ack_q    <= '0;
        end else begin
            ack_q <= ack_d;
            case (state_q)
                S_IDLE: begin
                    if (any_elig) begin
                        cur_q   <= win_ch;
                        bcnt_q  <= '0;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        grant_q <= win_oh;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (start_ready_i) begin
                        rr_ptr_q <= rr_next;
                        start_q  <= 1'b0;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    bcnt_q <= bcnt_d;
                    if (done_i) begin
                        busy_q  <= 1'b0;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else if (quantum_hit || !cur_en) begin
                        pause_q <= 1'b1;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (done_i || paused_i) begin
                        pause_q <= 1'b0;
                        busy_q  <= 1'b0;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign start_o      = start_q;
    assign start_ch_o   = cur_q;
    assign pause_o      = pause_q;
    assign busy_o       = busy_q;
    assign grant_o      = grant_q;
    assign periph_ack_o = ack_q;

endmodule

// File: tb/tb_dma_sched_ctrl.sv
// Self-checking bench for dma_sched_ctrl: arbitration vector table, directed corner sequences and a
// randomized run compared cycle by cycle against a behavioural scheduler model.
module tb_dma_sched_ctrl;
    localparam int N  = 4;
    localparam int PW = 2;
    localparam int Q  = 16;
    localparam int AL = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    ch_en, ch_pend, pmode, preq_in, ack, grant;
    logic [N*PW-1:0] prio;
    logic            start, ready, beat, done, paused, pause, busy;
    logic [1:0]      start_ch;

    int tests = 0;
    int fails = 0;

    dma_sched_ctrl #(
        .N_CHANNELS(N), .PRIO_W(PW), .QUANTUM_BEATS(Q), .AGE_LIMIT(AL)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .ch_en_i(ch_en), .ch_pend_i(ch_pend), .ch_prio_i(prio),
        .periph_mode_i(pmode), .periph_req_i(preq_in), .periph_ack_o(ack),
        .start_o(start), .start_ch_o(start_ch), .start_ready_i(ready),
        .beat_i(beat), .done_i(done), .paused_i(paused), .pause_o(pause),
        .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ch_en = '0; ch_pend = '0; pmode = '0; preq_in = '0; prio = '0;
        ready = 1'b0; beat = 1'b0; done = 1'b0; paused = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a start offer, checks the channel, accepts it and completes it with done.
    task automatic serve(input int exp_ch, input string tag);
        int waited;
        waited = 0;
        while (start !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        chk({tag, " start"}, start, 1);
        chk({tag, " channel"}, start_ch, exp_ch);
        chk({tag, " grant"}, grant, 1 << exp_ch);
        $display("[TB] %s: grant ch%0d after %0d wait cycles", tag, start_ch, waited);
        ready = 1'b1; tick(); ready = 1'b0;
        done = 1'b1; tick(); done = 1'b0;
        chk({tag, " idle gap"}, {start, busy}, 0);
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_owner;   // channel holding the engine, -1 when free
    int          m_last;    // last channel accepted by the engine, -1 after reset
    int          m_beats;
    bit          m_offered;
    bit          m_pausing;
    bit [N-1:0]  m_preq;
    bit [N-1:0]  m_ack;
    int          m_age [N];

    task automatic model_reset();
        m_owner = -1; m_last = -1; m_beats = 0;
        m_offered = 1'b0; m_pausing = 1'b0; m_preq = '0; m_ack = '0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
    endtask

    function automatic int key(input int n);
`ifdef DMA_SCHED_AGING_EN
        if (m_age[n] == AL) return 1 << PW;
`endif
        return int'(prio[n*PW +: PW]);
    endfunction

    task automatic model_step();
        bit [N-1:0] el;
        bit [N-1:0] ack_n;
        int         w;
        int         first;
        int         n;
        ack_n = '0;
        w     = -1;
        for (int i = 0; i < N; i++) el[i] = ch_en[i] & ch_pend[i] & (!pmode[i] | m_preq[i]);
        if (m_owner < 0) begin
            first = (m_last + 1) % N;
            for (int d = 0; d < N; d++) begin
                n = (first + d) % N;
                if (el[n] && (w < 0 || key(n) > key(w))) w = n;
            end
            if (w >= 0) begin
                m_owner = w; m_offered = 1'b1; m_beats = 0;
                $display("[TB] rand: grant ch%0d", w);
            end
        end else if (m_offered) begin
            if (ready) begin
                m_offered = 1'b0;
                m_last    = m_owner;
            end
        end else if (!m_pausing) begin
            if (beat && m_beats < Q) m_beats++;
            if (done) begin
                ack_n[m_owner] = pmode[m_owner];
                m_owner = -1;
            end else if (m_beats == Q || !ch_en[m_owner]) begin
                m_pausing = 1'b1;
            end
        end else if (done || paused) begin
            if (done) ack_n[m_owner] = pmode[m_owner];
            m_owner = -1; m_pausing = 1'b0;
        end
`ifdef DMA_SCHED_AGING_EN
        for (int i = 0; i < N; i++) begin
            if (!el[i] || i == w) m_age[i] = 0;
            else if (w >= 0 && m_age[i] < AL) m_age[i]++;
        end
`endif
        m_preq = (m_preq & ~ack_n) | preq_in;
        m_ack  = ack_n;
    endtask

    // ---------------- arbitration vector table ----------------
    typedef struct {
        logic [N-1:0]    en;
        logic [N-1:0]    pend;
        logic [N-1:0]    pm;
        logic [N*PW-1:0] pr;
        logic            exp_start;
        int              exp_ch;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [N-1:0] g_exp;
        logic [N-1:0] r;

        vecs[0] = '{4'hF, 4'hF, 4'h0, 8'h00, 1'b1, 0};
        vecs[1] = '{4'hF, 4'h0, 4'h0, 8'h00, 1'b0, 0};
        vecs[2] = '{4'hF, 4'hF, 4'h0, 8'h80, 1'b1, 3};
        vecs[3] = '{4'h7, 4'hF, 4'h0, 8'hC8, 1'b1, 1};
        vecs[4] = '{4'hF, 4'hA, 4'h0, 8'h44, 1'b1, 1};
        vecs[5] = '{4'hC, 4'hC, 4'h0, 8'h00, 1'b1, 2};
        vecs[6] = '{4'hF, 4'hF, 4'hF, 8'h00, 1'b0, 0};
        vecs[7] = '{4'hF, 4'hF, 4'h1, 8'h03, 1'b1, 1};
        vecs[8] = '{4'hF, 4'hF, 4'h0, 8'hF0, 1'b1, 2};

        clear_inputs();
        do_reset();
        chk("reset outputs", {start, pause, busy, grant, ack}, 0);

        foreach (vecs[i]) begin
            do_reset();
            ch_en = vecs[i].en; ch_pend = vecs[i].pend; pmode = vecs[i].pm; prio = vecs[i].pr;
            tick();
            chk($sformatf("vec%0d start", i), start, vecs[i].exp_start);
            if (vecs[i].exp_start) begin
                chk($sformatf("vec%0d channel", i), start_ch, vecs[i].exp_ch);
                chk($sformatf("vec%0d grant", i), grant, 1 << vecs[i].exp_ch);
            end else begin
                chk($sformatf("vec%0d busy", i), busy, 0);
            end
            $display("[TB] vec%0d: en=%b pend=%b pmode=%b prio=%h -> start=%b ch=%0d",
                     i, vecs[i].en, vecs[i].pend, vecs[i].pm, vecs[i].pr, start, start_ch);
        end

        // Reset mid-RUN, then two equal requests: rr_ptr must be back at 0.
        clear_inputs(); do_reset();
        ch_en = 4'b0010; ch_pend = 4'b0010;
        tick();
        chk("A first grant ch1", {start, start_ch}, {1'b1, 2'd1});
        ready = 1'b1; tick(); ready = 1'b0;
        beat = 1'b1; repeat (5) tick(); beat = 1'b0;
        chk("A busy mid-run", busy, 1);
        rst = 1'b1; #1;
        chk("A in reset", {start, busy, pause, grant, ack}, 0);
        tick(); rst = 1'b0;
        ch_en = 4'b0101; ch_pend = 4'b0101;
        chk("A after reset", {start, busy, grant}, 0);
        tick();
        chk("A regrant", {start, start_ch, grant}, {1'b1, 2'd0, 4'b0001});
        $display("[TB] A: reset mid-run, regrant ch%0d", start_ch);

        // Strict priority, then round-robin among equals.
        clear_inputs(); do_reset();
        ch_en = 4'b0111; ch_pend = 4'b0111; prio = 8'h35;
        serve(2, "B1");
        ch_pend[2] = 1'b0;
        serve(0, "B2");
        serve(1, "B3");
        serve(0, "B4");
        serve(1, "B5");

        // Quantum expiry followed by a paused return.
        clear_inputs(); do_reset();
        ch_en = 4'b0001; ch_pend = 4'b0001;
        tick();
        chk("C start", start, 1);
        ready = 1'b1; tick(); ready = 1'b0;
        beat = 1'b1;
        for (int i = 1; i <= Q; i++) begin
            tick();
            chk($sformatf("C pause after beat %0d", i), pause, i == Q);
        end
        beat = 1'b0;
        tick();
        chk("C pause held", pause, 1);
        paused = 1'b1; tick(); paused = 1'b0;
        chk("C idle after paused", {busy, pause, start, ack}, 0);
        tick();
        chk("C restart", {start, start_ch, ack}, {1'b1, 2'd0, 4'b0000});
        $display("[TB] C: quantum pause and restart of ch%0d", start_ch);

        // Peripheral pacing on ch3.
        clear_inputs(); do_reset();
        ch_en = 4'b1000; ch_pend = 4'b1000; pmode = 4'b1000;
        tick();
        chk("D no request no start", start, 0);
        preq_in = 4'b1000; tick(); preq_in = '0;
        tick();
        chk("D start ch3", {start, start_ch}, {1'b1, 2'd3});
        ready = 1'b1; tick(); ready = 1'b0;
        beat = 1'b1; repeat (4) tick(); beat = 1'b0;
        done = 1'b1; tick(); done = 1'b0;
        chk("D ack pulse", {ack, busy}, {4'b1000, 1'b0});
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("D quiet %0d", i), {start, ack}, 0);
        end
        preq_in = 4'b1000; tick(); preq_in = '0;
        tick();
        chk("D regrant ch3", {start, start_ch}, {1'b1, 2'd3});
        $display("[TB] D: peripheral ack once, regrant ch%0d on new request", start_ch);

        // Enable drop in RUN, then done and paused together.
        ready = 1'b1; tick(); ready = 1'b0;
        ch_en[3] = 1'b0;
        tick();
        chk("E pause on enable drop", pause, 1);
        done = 1'b1; paused = 1'b1; tick(); done = 1'b0; paused = 1'b0;
        chk("E done+paused ack", {ack, busy, pause}, {4'b1000, 1'b0, 1'b0});
        tick();
        chk("E ack single cycle", ack, 0);
        $display("[TB] E: enable drop paused, done+paused acked");

        // Start held while the engine is not ready.
        clear_inputs(); do_reset();
        ch_en = 4'b0100; ch_pend = 4'b0100;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("F stall %0d", i), {start, start_ch}, {1'b1, 2'd2});
            tick();
        end
        chk("F stall end", {start, start_ch}, {1'b1, 2'd2});
        ready = 1'b1; tick(); ready = 1'b0;
        chk("F accepted", {start, busy}, 2'b01);
        $display("[TB] F: start held through ready stall");

        // done in the same cycle the quantum is reached.
        clear_inputs(); do_reset();
        ch_en = 4'b0001; ch_pend = 4'b0001;
        tick();
        ready = 1'b1; tick(); ready = 1'b0;
        beat = 1'b1; repeat (Q - 1) tick();
        chk("G no pause before quantum", pause, 0);
        done = 1'b1; tick(); beat = 1'b0; done = 1'b0;
        chk("G done wins over quantum", {busy, pause}, 0);
        $display("[TB] G: done at quantum goes idle without pause");

`ifdef DMA_SCHED_AGING_EN
        clear_inputs(); do_reset();
        ch_en = 4'b0011; ch_pend = 4'b0011; prio = 8'h0C;
        serve(1, "H1");
        serve(1, "H2");
        serve(0, "H3");
`endif

        // Randomized run against the model.
        clear_inputs();
        ch_en = '1; ch_pend = '1; pmode = 4'b1000;
        do_reset(); model_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                do_reset(); model_reset();
            end
            if ($urandom_range(99) < 2) ch_en[$urandom_range(N-1)] ^= 1'b1;
            if ($urandom_range(99) < 5) ch_pend[$urandom_range(N-1)] ^= 1'b1;
            if ($urandom_range(99) < 1) pmode[$urandom_range(N-1)] ^= 1'b1;
            if ($urandom_range(99) < 3) prio = N*PW'($urandom);
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(99) < 4);
            preq_in = r;
            ready  = ($urandom_range(99) < 50);
            beat   = ($urandom_range(99) < 60);
            done   = ($urandom_range(99) < 4);
            paused = ($urandom_range(99) < 25);
            model_step();
            tick();
            g_exp = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            chk($sformatf("rand c%0d start/pause/busy/grant/ack", c),
                {start, pause, busy, grant, ack},
                {m_offered && (m_owner >= 0), m_pausing, m_owner >= 0, g_exp, m_ack});
            if (m_owner >= 0) chk($sformatf("rand c%0d channel", c), start_ch, m_owner);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
